gamepad_pmod_emitter: RTL and testbench
=======================================

# gamepad_pmod_emitter

Transmit side of the Gamepad Pmod serial link. It produces `pmod_data`, `pmod_clk` and `pmod_latch` so that our existing Pmod receive driver reconstructs the supplied button states bit-exactly. It sits in bench harnesses and in designs that emulate a gamepad toward another Tiny Tapeout design. It snapshots one or two controllers' button vectors, shifts them out MSB-first and closes each frame with a latch pulse.

## Interface
- `NUM_PADS`, default 2: controllers per frame, 1 or 2. Frame length N = 12·NUM_PADS bits.
- `HALF_CYCLES`, default 4: `clk` cycles per pmod_clk half-period. Must be ≥3 so the receiver's 2-FF synchronizers resolve each edge.
- `GAP_CYCLES`, default 8: idle cycles after each latch pulse. Must be ≥1.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `btn0` input 12: controller 0 buttons in order {b,y,select,start,up,down,left,right,a,x,l,r}, bit 11 = b; 1 = pressed.
- `btn1` input 12: controller 1 buttons, same order. Ignored when NUM_PADS=1.
- `present` input 2: controller i connected. Bit 1 is ignored when NUM_PADS=1.
- `frame_req` input 1: request a frame. Sampled only in IDLE.
- `busy` output 1: high from the cycle after acceptance until the return to IDLE.
- `frame_done` output 1: one-cycle pulse on the first GAP cycle.
- `pmod_data`, `pmod_clk`, `pmod_latch` output 1 each: serial link, all registered.

## Operation
- Snapshot on acceptance: word = {pad1, pad0} when NUM_PADS=2, else pad0.
  - pad_i = present[i] ? btn_i : 12'hFFF.
  - Input changes during a frame have no effect on that frame.
- A present pad with all 12 buttons pressed is sent as 12'hFFF unchanged. The receiver then reports it absent; this is protocol-inherent.
- Bits go out word[N-1] first, word[0] last. Per bit, clk is high for H cycles with the data valid, then low for H cycles with the data held.
- The receiver samples on each pmod_clk falling edge. Data is therefore stable H cycles either side of that edge.
- FSM states:
  - IDLE: leave when frame_req=1; snapshot; bit index = N-1.
  - SHIFT_HI: after H cycles, go to SHIFT_LO.
  - SHIFT_LO: after H cycles, decrement the bit index and go to SHIFT_HI. If the index is 0, go to LATCH.
  - LATCH: after H cycles, go to GAP.
  - GAP: after GAP_CYCLES cycles, go to IDLE.
- Counters:
  - Phase counter width is $clog2(max(HALF_CYCLES, GAP_CYCLES)).
  - Bit counter width is $clog2(N); it never wraps below 0.
- frame_req while busy is ignored; there is no queueing.
- Reset values: all outputs 0, state IDLE, snapshot 0.
- Reset mid-frame forces outputs low immediately. No latch rising edge is produced, so the receiver keeps its previous word.

## Timing
- Cycle 0 is the cycle in which frame_req is sampled high in IDLE. H = HALF_CYCLES.
- Bit k (k=0 first sent):
  - pmod_clk=1 on cycles 2Hk+1 … 2Hk+H.
  - pmod_clk=0 on cycles 2Hk+H+1 … 2H(k+1).
  - pmod_data = word[N-1-k] on cycles 2Hk+1 … 2H(k+1).
- pmod_latch=1 on cycles 2HN+1 … 2HN+H, with pmod_data=0 and pmod_clk=0.
- GAP occupies cycles 2HN+H+1 … 2HN+H+GAP_CYCLES. frame_done=1 on cycle 2HN+H+1.
- busy=1 on cycles 1 … 2HN+H+GAP_CYCLES. IDLE is reached the following cycle, and a frame_req in that cycle is accepted.
- The receiver's data_reg updates 3 cycles after the latch rises.

## Configuration
- `GAMEPAD_PMOD_EMITTER_AUTO_EN` defined: free-running mode.
  - The first frame is accepted in the first cycle after reset deasserts.
  - GAP transitions directly to SHIFT_HI with a fresh snapshot.
  - frame_req is ignored; busy stays 1 after the first frame starts.
  - Frame period is 2HN+H+GAP_CYCLES cycles.
- Not defined: frames are sent only on frame_req, as above.

## Test plan
- Dual-pad frame, defaults. Stimulus: btn0=12'h800, btn1=12'h001, present=2'b11, frame_req pulse.
  - 24 falling edges; bit stream 000000000001_100000000000.
  - Latch high cycles 193–196; frame_done at 197; busy falls at 205.
  - Receiver data_reg = 24'h001800; b[0]=1, r[1]=1.
- Absent pad. Stimulus: present=2'b01, btn1=12'h0AA.
  - Upper 12 bits sent as FFF.
  - Receiver is_present = 2'b01; btn1 not visible.
- Snapshot and handshake.
  - btn0 changed at cycle 20 → the frame carries the cycle-0 value.
  - frame_req at cycle 50 → ignored.
  - frame_req at cycle 205 → accepted; next clk high at 206.
- Reset mid-frame. Stimulus: rst asserted at cycle 60.
  - All outputs 0 immediately.
  - Receiver data_reg holds its prior value.
  - The next requested frame decodes correctly.
- Single pad. Stimulus: NUM_PADS=1, H=3, btn0=12'h5A5.
  - 12 falling edges; latch cycles 73–75; frame_done at 76.
  - Receiver (12-bit) data_reg = 12'h5A5.
- Auto mode. Stimulus: AUTO_EN defined, defaults.
  - Consecutive latch rising edges are exactly 204 cycles apart.
  - frame_req has no effect.

Source files
------------

// File: rtl/gamepad_pmod_emitter.sv
// gamepad_pmod_emitter
//
// Transmit side of the Gamepad Pmod serial link. Takes a snapshot of one or two
// controllers' button vectors and shifts them out MSB-first on pmod_data/pmod_clk.
// Each frame ends with a pmod_latch pulse, and the receive driver then reconstructs
// the supplied button states bit-exactly.
//
// Parameters:
//   NUM_PADS     controllers per frame (1 or 2); frame length N = 12*NUM_PADS bits
//   HALF_CYCLES  clk cycles per pmod_clk half-period (>= 3)
//   GAP_CYCLES   idle cycles after each latch pulse (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   btn0/btn1   button vectors {b,y,select,start,up,down,left,right,a,x,l,r}, 1 = pressed
//   present     per-controller connected flag
//   frame_req   frame request, sampled only while idle
//   busy        high from the cycle after acceptance until the return to idle
//   frame_done  one-cycle pulse on the first gap cycle
//   pmod_data, pmod_clk, pmod_latch   registered serial link outputs
//
// Optional build macro GAMEPAD_PMOD_EMITTER_AUTO_EN: free-running mode. Frames are
// sent back to back starting right after reset, and frame_req is ignored.

module gamepad_pmod_emitter #(
    parameter int NUM_PADS    = 2,
    parameter int HALF_CYCLES = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] btn0,
    input  logic [11:0] btn1,
    input  logic [1:0]  present,
    input  logic        frame_req,
    output logic        busy,
    output logic        frame_done,
    output logic        pmod_data,
    output logic        pmod_clk,
    output logic        pmod_latch
);

    localparam int N      = 12 * NUM_PADS;
    localparam int PH_MAX = (HALF_CYCLES > GAP_CYCLES) ? HALF_CYCLES : GAP_CYCLES;
    localparam int PW     = $clog2(PH_MAX);
    localparam int BW     = $clog2(N);

    localparam logic [PW-1:0] H_LAST = PW'(HALF_CYCLES - 1);
    localparam logic [PW-1:0] G_LAST = PW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] B_TOP  = BW'(N - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT_HI = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_LATCH    = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;

    // Elaboration-time parameter sanity.
    if (NUM_PADS != 1 && NUM_PADS != 2) begin : g_bad_pads
        $error("gamepad_pmod_emitter: NUM_PADS must be 1 or 2");
    end
    if (HALF_CYCLES < 3) begin : g_bad_half
        $error("gamepad_pmod_emitter: HALF_CYCLES must be >= 3");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("gamepad_pmod_emitter: GAP_CYCLES must be >= 1");
    end

    // Absent pads read as all-ones, which the receiver decodes as "not connected".
    logic [11:0]  pad0;
    logic [N-1:0] snap;

    assign pad0 = present[0] ? btn0 : 12'hFFF;

    if (NUM_PADS == 2) begin : g_two_pads
        logic [11:0] pad1;
        assign pad1 = present[1] ? btn1 : 12'hFFF;
        assign snap = {pad1, pad0};
    end else begin : g_one_pad
        logic unused_pad1;
        assign unused_pad1 = ^{btn1, present[1]};
        assign snap        = pad0;
    end

    // Start condition taken in IDLE.
    logic start;
`ifdef GAMEPAD_PMOD_EMITTER_AUTO_EN
    logic unused_frame_req;
    assign unused_frame_req = frame_req;
    assign start            = 1'b1;
`else
    assign start = frame_req;
`endif

    // State.
    logic [2:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [N-1:0]  word_q, word_d;
    logic          done_d;
    logic          h_end, g_end;

    assign h_end = (phase_q == H_LAST);
    assign g_end = (phase_q == G_LAST);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        word_d  = word_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT_HI;
                    phase_d = '0;
                    bit_d   = B_TOP;
                    word_d  = snap;
                end
            end

            S_SHIFT_HI: begin
                if (h_end) begin
                    state_d = S_SHIFT_LO;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_SHIFT_LO: begin
                if (h_end) begin
                    phase_d = '0;
                    // Index saturates at 0; the last bit hands over to the latch.
                    if (bit_q == '0) begin
                        state_d = S_LATCH;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        state_d = S_SHIFT_HI;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_LATCH: begin
                if (h_end) begin
                    state_d = S_GAP;
                    phase_d = '0;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_GAP: begin
                if (g_end) begin
                    phase_d = '0;
`ifdef GAMEPAD_PMOD_EMITTER_AUTO_EN
                    // Back-to-back frames: resnapshot and skip IDLE entirely.
                    state_d = S_SHIFT_HI;
                    bit_d   = B_TOP;
                    word_d  = snap;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    logic shifting_d;
    logic data_d;

    assign shifting_d = (state_d == S_SHIFT_HI) || (state_d == S_SHIFT_LO);
    assign data_d     = shifting_d ? word_d[bit_d] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            word_q     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pmod_data  <= 1'b0;
            pmod_clk   <= 1'b0;
            pmod_latch <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            busy       <= (state_d != S_IDLE);
            frame_done <= done_d;
            pmod_data  <= data_d;
            pmod_clk   <= (state_d == S_SHIFT_HI);
            pmod_latch <= (state_d == S_LATCH);
        end
    end

endmodule

// File: tb/tb_gamepad_pmod_emitter.sv
// Testbench for gamepad_pmod_emitter: a dual-pad instance (defaults) and a
// single-pad instance (HALF_CYCLES=3). Decoded frames are compared against a
// scoreboard of words predicted from the stimulus at request time.

module tb_gamepad_pmod_emitter;

    localparam int H0 = 4;
    localparam int G0 = 8;
    localparam int N0 = 24;
    localparam int H1 = 3;
    localparam int N1 = 12;
    localparam int G1 = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] btn0 = '0;
    logic [11:0] btn1 = '0;
    logic [1:0]  present = '0;
    logic        frame_req0 = 1'b0;
    logic        frame_req1 = 1'b0;

    logic busy0, done0, data0, pclk0, latch0;
    logic busy1, done1, data1, pclk1, latch1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gamepad_pmod_emitter #(.NUM_PADS(2), .HALF_CYCLES(H0), .GAP_CYCLES(G0)) u_dut (
        .clk(clk), .rst(rst), .btn0(btn0), .btn1(btn1), .present(present),
        .frame_req(frame_req0), .busy(busy0), .frame_done(done0),
        .pmod_data(data0), .pmod_clk(pclk0), .pmod_latch(latch0)
    );

    gamepad_pmod_emitter #(.NUM_PADS(1), .HALF_CYCLES(H1), .GAP_CYCLES(G1)) u_dut1 (
        .clk(clk), .rst(rst), .btn0(btn0), .btn1(btn1), .present(present),
        .frame_req(frame_req1), .busy(busy1), .frame_done(done1),
        .pmod_data(data1), .pmod_clk(pclk1), .pmod_latch(latch1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] exp_word(input logic [11:0] b0, input logic [11:0] b1,
                                             input logic [1:0] p);
        return {p[1] ? b1 : 12'hFFF, p[0] ? b0 : 12'hFFF};
    endfunction

    // Scoreboards and a receiver-equivalent decoder for the dual-pad instance.
    logic [23:0] exp0_q[$];
    logic [11:0] exp1_q[$];
    int          acc0 = 0;
    logic [23:0] rx_sh0 = '0;
    logic [23:0] rx_data0 = '0;
    int          falls0 = 0;
    int          lat_cnt0 = 0;
    int          done_cnt0 = 0;
    logic        prev_clk0 = 1'b0;
    logic        prev_latch0 = 1'b0;
    logic        prev_busy0 = 1'b0;
    logic        rise_data0 = 1'b0;

`ifndef GAMEPAD_PMOD_EMITTER_AUTO_EN
    always @(negedge clk) begin
        if (rst) begin
            falls0 = 0;
        end else begin
            if (pclk0 && !prev_clk0) rise_data0 = data0;
            if (!pclk0 && prev_clk0) begin
                check("data_hold", 32'(data0), 32'(rise_data0));
                rx_sh0 = {rx_sh0[22:0], data0};
                falls0++;
            end
            if (latch0) check("latch_lines", 32'({pclk0, data0}), 32'd0);
            if (latch0 && !prev_latch0) begin
                lat_cnt0++;
                rx_data0 = rx_sh0;
                check("latch_cycle", cyc - acc0, 2 * H0 * N0 + 1);
                check("fall_edges", falls0, N0);
                falls0 = 0;
                check("sb_depth", exp0_q.size(), 1);
                if (exp0_q.size() > 0) check("frame_word", 32'(rx_sh0), 32'(exp0_q.pop_front()));
            end
            if (done0) begin
                done_cnt0++;
                check("done_cycle", cyc - acc0, 2 * H0 * N0 + H0 + 1);
            end
            if (prev_busy0 && !busy0) check("busy_fall", cyc - acc0, 2 * H0 * N0 + H0 + G0 + 1);
        end
        prev_clk0   = pclk0;
        prev_latch0 = latch0;
        prev_busy0  = busy0;
    end
`endif

    // Request a frame on the dual-pad instance and check the first active cycle.
    task automatic start0();
        @(negedge clk); #1;
        frame_req0 = 1'b1;
        acc0 = cyc;
        exp0_q.push_back(exp_word(btn0, btn1, present));
        @(negedge clk); #1;
        frame_req0 = 1'b0;
        check("start_busy_clk", 32'({busy0, pclk0}), 32'b11);
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (busy0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(busy0), 32'd0);
        check("done_pulses", done_cnt0, 1);
        check("latch_rises", lat_cnt0, 1);
        done_cnt0 = 0;
        lat_cnt0  = 0;
    endtask

    // One frame on the single-pad instance, decoded and timed inline.
    task automatic run_single(input logic [11:0] b);
        logic [11:0] sh = '0;
        int falls = 0, lat_rel = -1, lat_len = 0, done_rel = -1, busy_rel = -1, acc;
        logic pc = 1'b0, pb = 1'b0, pl = 1'b0;
        btn0    = b;
        present = 2'b01;
        @(negedge clk); #1;
        frame_req1 = 1'b1;
        acc = cyc;
        exp1_q.push_back(present[0] ? btn0 : 12'hFFF);
        for (int i = 1; i <= 90; i++) begin
            @(negedge clk);
            if (i == 1) frame_req1 = 1'b0;
            if (!pclk1 && pc) begin
                sh = {sh[10:0], data1};
                falls++;
            end
            if (latch1) begin
                lat_len++;
                if (!pl) begin
                    lat_rel = cyc - acc;
                    if (exp1_q.size() > 0) check("single_word", 32'(sh), 32'(exp1_q.pop_front()));
                end
            end
            if (done1) done_rel = cyc - acc;
            if (pb && !busy1) busy_rel = cyc - acc;
            pc = pclk1;
            pb = busy1;
            pl = latch1;
        end
        check("single_falls", falls, N1);
        check("single_latch_cycle", lat_rel, 2 * H1 * N1 + 1);
        check("single_latch_len", lat_len, H1);
        check("single_done_cycle", done_rel, 2 * H1 * N1 + H1 + 1);
        check("single_busy_fall", busy_rel, 2 * H1 * N1 + H1 + G1 + 1);
        check("single_sb_drained", exp1_q.size(), 0);
        check("single_word_const", 32'(sh), 32'h5A5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy0, done0, data0, pclk0, latch0}), 32'd0);
        #1 rst = 1'b0;
`ifndef GAMEPAD_PMOD_EMITTER_AUTO_EN
        @(negedge clk); #1;
        check("idle_outputs", 32'({busy0, done0, data0, pclk0, latch0}), 32'd0);

        // Dual pad, one button on each.
        btn0 = 12'h800; btn1 = 12'h001; present = 2'b11;
        start0();
        wait_idle0();
        check("rx_word", 32'(rx_data0), 32'h001800);
        check("b_pad0", 32'(rx_data0[11]), 32'd1);
        check("r_pad1", 32'(rx_data0[12]), 32'd1);

        // Pad 1 absent: its buttons must not appear.
        btn0 = 12'h123; btn1 = 12'h0AA; present = 2'b01;
        start0();
        wait_idle0();
        check("upper_fff", 32'(rx_data0[23:12]), 32'hFFF);
        check("is_present", 32'({rx_data0[23:12] != 12'hFFF, rx_data0[11:0] != 12'hFFF}), 32'b01);

        // Snapshot, ignored request while busy, back-to-back acceptance.
        btn0 = 12'h3C3; btn1 = 12'h00F; present = 2'b11;
        @(negedge clk); #1;
        frame_req0 = 1'b1;
        acc0 = cyc;
        exp0_q.push_back(exp_word(btn0, btn1, present));
        for (int r = 1; r <= 205; r++) begin
            @(negedge clk); #1;
            if (r == 1) frame_req0 = 1'b0;
            if (r == 20) btn0 = 12'hC3C;
            if (r == 50) frame_req0 = 1'b1;
            if (r == 51) frame_req0 = 1'b0;
        end
        check("idle_at_205", 32'(busy0), 32'd0);
        check("snap_word", 32'(rx_data0), 32'h00F3C3);
        check("done_pulses_t3", done_cnt0, 1);
        check("latch_rises_t3", lat_cnt0, 1);
        done_cnt0 = 0;
        lat_cnt0  = 0;
        frame_req0 = 1'b1;
        acc0 = cyc;
        exp0_q.push_back(exp_word(btn0, btn1, present));
        @(negedge clk); #1;
        frame_req0 = 1'b0;
        check("restart_clk_206", 32'(pclk0), 32'd1);
        wait_idle0();
        check("second_word", 32'(rx_data0), 32'h00FC3C);

        // Reset in the middle of a frame.
        btn0 = 12'h0F0;
        start0();
        while (cyc - acc0 < 60) begin
            @(negedge clk); #1;
        end
        check("pre_reset_clk", 32'(pclk0), 32'd1);
        rst = 1'b1;
        #1;
        check("reset_mid_outputs", 32'({busy0, done0, data0, pclk0, latch0}), 32'd0);
        exp0_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        check("rx_hold", 32'(rx_data0), 32'h00FC3C);
        done_cnt0 = 0;
        lat_cnt0  = 0;
        btn0 = 12'h5A5; btn1 = 12'h7E1;
        start0();
        wait_idle0();
        check("post_reset_word", 32'(rx_data0), 32'h7E15A5);

        // Single pad instance.
        run_single(12'h5A5);

        check("sb_drained", exp0_q.size(), 0);
`else
        begin
            int last = -1;
            int seen = 0;
            logic pl = 1'b0;
            for (int i = 0; i < 1000 && seen < 4; i++) begin
                @(negedge clk); #1;
                frame_req0 = i[3];
                if (latch0 && !pl) begin
                    if (last >= 0) check("auto_period", cyc - last, 2 * H0 * N0 + H0 + G0);
                    last = cyc;
                    seen++;
                end
                pl = latch0;
            end
            check("auto_frames", seen, 4);
            check("auto_busy", 32'(busy0), 32'd1);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
